// File: rtl/sp_ram_lsu_bridge.sv
// Core load/store port to single-port RAM bridge; word-crossing accesses become two RAM cycles.
// Optional range checking via `define SP_RAM_LSU_ACCESS_ERR_EN (off by default).
module sp_ram_lsu_bridge #(
   parameter int RAM_SIZE   = 32768,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [31:0]           addr_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic                  ram_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   // state  | meaning
   // IDLE   | nothing in flight, accepts a request
   // SECOND | upper half of a split access on the RAM port, no grant
   // RESP   | response cycle; accepts a new request like IDLE
   typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              off;
   logic [3:0]              nbytes;
   logic [7:0]              base_mask, lane_mask;
   logic                    split, acc_err;
   logic [ADDR_WIDTH-1:0]   first_addr;
   logic [2*DATA_WIDTH-1:0] wide_wdata;

   logic [ADDR_WIDTH-1:0]   sec_addr_q;
   logic [3:0]              sec_be_q;
   logic [DATA_WIDTH-1:0]   sec_wdata_q;
   logic                    sec_we_q;
   logic [DATA_WIDTH-1:0]   held_q;
   logic [1:0]              rsp_off_q, rsp_size_q;
   logic                    rsp_we_q, rsp_split_q;
   logic                    rvalid_q, err_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [2*DATA_WIDTH-1:0] rsp_cat, rsp_shift;
   logic [DATA_WIDTH-1:0]   rsp_mask, rsp_data;

   assign off        = addr_i[1:0];
   assign nbytes     = (size_i == 2'd0) ? 4'd1 : (size_i == 2'd1) ? 4'd2 : 4'd4;
   assign base_mask  = (size_i == 2'd0) ? 8'h01 : (size_i == 2'd1) ? 8'h03 : 8'h0F;
   assign lane_mask  = base_mask << off;
   assign split      = |lane_mask[7:4];
   assign first_addr = {addr_i[ADDR_WIDTH-1:2], 2'b00};
   // Low half feeds the first access, high half the second of a split store.
   assign wide_wdata = {{DATA_WIDTH{1'b0}}, wdata_i} << {off, 3'b000};

`ifdef SP_RAM_LSU_ACCESS_ERR_EN
   logic [32:0] last_byte;
   assign last_byte = {1'b0, addr_i} + {29'd0, nbytes} - 33'd1;
   assign acc_err   = ({1'b0, addr_i} >= 33'(RAM_SIZE)) || (last_byte >= 33'(RAM_SIZE));
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^{addr_i[31:ADDR_WIDTH], nbytes};
   assign acc_err        = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_o       = 1'b0;
      ram_en_o    = 1'b0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = 4'b0000;
      ram_wdata_o = '0;
      if (!rst_i) begin
         case (state_q)
            SECOND: begin
               ram_en_o    = 1'b1;
               ram_addr_o  = sec_addr_q;
               ram_we_o    = sec_we_q;
               ram_be_o    = sec_be_q;
               ram_wdata_o = sec_wdata_q;
               state_d     = RESP;
            end
            default: begin
               gnt_o   = req_i;
               state_d = IDLE;
               if (req_i) begin
                  state_d = (split && !acc_err) ? SECOND : RESP;
                  if (!acc_err) begin
                     ram_en_o    = 1'b1;
                     ram_addr_o  = first_addr;
                     ram_we_o    = we_i;
                     ram_be_o    = lane_mask[3:0];
                     ram_wdata_o = wide_wdata[DATA_WIDTH-1:0];
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         if (rvalid_q) rdata_q <= rsp_data;
         if (gnt_o) begin
            rsp_off_q   <= off;
            rsp_size_q  <= size_i;
            rsp_we_q    <= we_i;
            rsp_split_q <= split && !acc_err;
            if (split && !acc_err) begin
               sec_addr_q  <= first_addr + ADDR_WIDTH'(4);
               sec_be_q    <= lane_mask[7:4];
               sec_wdata_q <= wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
               sec_we_q    <= we_i;
            end else begin
               rvalid_q <= 1'b1;
               err_q    <= acc_err;
            end
         end
         if (state_q == SECOND) begin
            held_q   <= ram_rdata_i;
            rvalid_q <= 1'b1;
         end
      end
   end

   // Load merge: the lower word of a split was captured during the second access.
   assign rsp_cat   = rsp_split_q ? {ram_rdata_i, held_q} : {{DATA_WIDTH{1'b0}}, ram_rdata_i};
   assign rsp_shift = rsp_cat >> {rsp_off_q, 3'b000};
   assign rsp_mask  = (rsp_size_q == 2'd0) ? DATA_WIDTH'(32'h0000_00FF) :
                      (rsp_size_q == 2'd1) ? DATA_WIDTH'(32'h0000_FFFF) : {DATA_WIDTH{1'b1}};
   assign rsp_data  = (rsp_we_q || err_q) ? '0 : (rsp_shift[DATA_WIDTH-1:0] & rsp_mask);

   assign rvalid_o = rvalid_q && !rst_i;
   assign err_o    = err_q && rvalid_q && !rst_i;
   assign rdata_o  = rst_i ? '0 : (rvalid_q ? rsp_data : rdata_q);

endmodule

// File: tb/tb_sp_ram_lsu_bridge.sv
// Bench for sp_ram_lsu_bridge: byte-level reference memory model plus directed literal checks.
module tb_sp_ram_lsu_bridge;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_i, req_i, we_i;
   logic [1:0]    size_i;
   logic [31:0]   addr_i, wdata_i;
   logic          gnt_o, rvalid_o, err_o, ram_en_o, ram_we_o;
   logic [31:0]   rdata_o, ram_wdata_o, ram_rdata_i;
   logic [AW-1:0] ram_addr_o;
   logic [3:0]    ram_be_o;

   int checks = 0;
   int errors = 0;

   sp_ram_lsu_bridge #(.RAM_SIZE(32768)) dut (
      .clk(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .size_i(size_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
      .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // RAM behind the bridge
   bit [7:0] stub [0:65535];
   always @(posedge clk) begin
      if (ram_en_o) begin
         for (int k = 0; k < 4; k++)
            if (ram_we_o && ram_be_o[k]) stub[{ram_addr_o[AW-1:2], 2'(k)}] <= ram_wdata_o[8*k +: 8];
         ram_rdata_i <= {stub[{ram_addr_o[AW-1:2], 2'd3}], stub[{ram_addr_o[AW-1:2], 2'd2}],
                         stub[{ram_addr_o[AW-1:2], 2'd1}], stub[{ram_addr_o[AW-1:2], 2'd0}]};
      end
   end

   // Reference model: what the core should see, byte by byte
   typedef struct {int due; logic [31:0] data; logic err;} rsp_t;
   bit [7:0]    ref_mem [0:65535];
   rsp_t        rq[$];
   int          cyc = 0;
   bit          sec_pend = 1'b0;
   logic [15:0] sec_addr;
   logic [3:0]  sec_be;
   logic        sec_we;
   logic [31:0] last_rdata = 32'h0;

   always @(negedge clk) begin : model
      int n, o;
      logic exp_gnt, exp_en, exp_we, err, split, new_pend;
      logic [15:0] base, exp_addr, a;
      logic [3:0] be1, be2, exp_be;
      logic [31:0] data;
      rsp_t r;
`ifdef SP_RAM_LSU_ACCESS_ERR_EN
      longint last;
`endif
      cyc++;
      if (rst_i) begin
         chk("rst_gnt", 32'(gnt_o), 0);
         chk("rst_en", 32'(ram_en_o), 0);
         chk("rst_rvalid", 32'(rvalid_o), 0);
         chk("rst_rdata", rdata_o, 0);
         rq.delete();
         sec_pend   = 1'b0;
         last_rdata = 32'h0;
      end else begin
         exp_gnt = req_i && !sec_pend;
         chk("m_gnt", 32'(gnt_o), 32'(exp_gnt));
         exp_en = 1'b0; exp_addr = '0; exp_be = '0; exp_we = 1'b0; new_pend = 1'b0;
         if (sec_pend) begin
            exp_en = 1'b1; exp_addr = sec_addr; exp_be = sec_be; exp_we = sec_we;
         end
         if (exp_gnt) begin
            o    = int'(addr_i[1:0]);
            n    = (size_i == 2'd0) ? 1 : (size_i == 2'd1) ? 2 : 4;
            base = {addr_i[15:2], 2'b00};
`ifdef SP_RAM_LSU_ACCESS_ERR_EN
            last = longint'(addr_i) + longint'(n) - 1;
            err  = (longint'(addr_i) >= 32768) || (last >= 32768);
`else
            err  = 1'b0;
`endif
            be1 = '0; be2 = '0;
            for (int k = 0; k < n; k++)
               if (o + k < 4) be1[o+k] = 1'b1; else be2[o+k-4] = 1'b1;
            split = (o + n > 4) && !err;
            data  = 32'h0;
            if (!err) begin
               exp_en = 1'b1; exp_addr = base; exp_be = be1; exp_we = we_i;
               for (int k = 0; k < n; k++) begin
                  a = addr_i[15:0] + 16'(k);
                  if (we_i) ref_mem[a] = wdata_i[8*k +: 8];
                  else data = data | (32'(ref_mem[a]) << (8*k));
               end
            end
            if (split) begin
               new_pend = 1'b1; sec_addr = base + 16'd4; sec_be = be2; sec_we = we_i;
            end
            r.due = cyc + (split ? 2 : 1); r.data = data; r.err = err;
            rq.push_back(r);
         end
         chk("m_en", 32'(ram_en_o), 32'(exp_en));
         if (exp_en) begin
            chk("m_addr", 32'(ram_addr_o), 32'(exp_addr));
            chk("m_be", 32'(ram_be_o), 32'(exp_be));
            chk("m_we", 32'(ram_we_o), 32'(exp_we));
         end
         sec_pend = new_pend;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("m_rvalid", 32'(rvalid_o), 1);
            chk("m_rdata", rdata_o, rq[0].data);
            chk("m_err", 32'(err_o), 32'(rq[0].err));
            last_rdata = rq[0].data;
            void'(rq.pop_front());
         end else begin
            chk("m_rvalid_idle", 32'(rvalid_o), 0);
            chk("m_rdata_hold", rdata_o, last_rdata);
         end
      end
   end

   task automatic drive(input logic rq_v, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      req_i = rq_v; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
   endtask
   task automatic idle(); drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0); endtask
   task automatic tick(); @(posedge clk); #1; endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lane;
      rst_i = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_gnt", 32'(gnt_o), 0);
         chk("reset_en", 32'(ram_en_o), 0);
         tick();
      end
      rst_i = 1'b0;
      @(negedge clk);
      chk("first_gnt", 32'(gnt_o), 1);
      chk("first_en", 32'(ram_en_o), 1);
      tick();

      drive(1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
      @(negedge clk);
      chk("st_be", 32'(ram_be_o), 32'hF);
      chk("st_addr", 32'(ram_addr_o), 32'h100);
      chk("st_wdata", ram_wdata_o, 32'hDEADBEEF);
      tick();
      drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
      @(negedge clk); tick();
      idle();
      @(negedge clk);
      chk("ld_rvalid", 32'(rvalid_o), 1);
      chk("ld_rdata", rdata_o, 32'hDEADBEEF);
      tick();

      drive(1'b1, 1'b1, 2'd0, 32'h102, 32'h000000A5);
      @(negedge clk);
      chk("stb_be", 32'(ram_be_o), 32'h4);
      lane = (ram_wdata_o >> 16) & 32'hFF;
      chk("stb_lane", lane, 32'hA5);
      tick();
      drive(1'b1, 1'b1, 2'd2, 32'h100, 32'h1234ABCD);
      @(negedge clk); tick();
      drive(1'b1, 1'b0, 2'd1, 32'h102, 32'h0);
      @(negedge clk);
      chk("ldh_be", 32'(ram_be_o), 32'hC);
      tick();
      idle();
      @(negedge clk);
      chk("ldh_rdata", rdata_o, 32'h00001234);
      tick();

      drive(1'b1, 1'b1, 2'd2, 32'h1FC, 32'h44332211);
      @(negedge clk); tick();
      drive(1'b1, 1'b1, 2'd2, 32'h200, 32'h88776655);
      @(negedge clk); tick();
      drive(1'b1, 1'b0, 2'd2, 32'h1FE, 32'h0);
      @(negedge clk);
      chk("spl_gnt0", 32'(gnt_o), 1);
      chk("spl_addr0", 32'(ram_addr_o), 32'h1FC);
      chk("spl_be0", 32'(ram_be_o), 32'hC);
      tick();
      @(negedge clk);
      chk("spl_gnt1", 32'(gnt_o), 0);
      chk("spl_addr1", 32'(ram_addr_o), 32'h200);
      chk("spl_be1", 32'(ram_be_o), 32'h3);
      chk("spl_rv1", 32'(rvalid_o), 0);
      tick();
      idle();
      @(negedge clk);
      chk("spl_rvalid", 32'(rvalid_o), 1);
      chk("spl_rdata", rdata_o, 32'h66554433);
      tick();

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 2'd2, 32'h300 + 32'(4*i), 32'h11110000 + 32'(i));
         @(negedge clk); tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 2'd2, 32'h300 + 32'(4*i), 32'h0);
         @(negedge clk);
         chk("b2b_gnt", 32'(gnt_o), 1);
         if (i > 0) begin
            chk("b2b_rvalid", 32'(rvalid_o), 1);
            chk("b2b_rdata", rdata_o, 32'h11110000 + 32'(i - 1));
         end
         tick();
      end
      idle();
      @(negedge clk);
      chk("b2b_last", rdata_o, 32'h11110003);
      tick();

      drive(1'b1, 1'b1, 2'd2, 32'h401, 32'hCAFEF00D);
      @(negedge clk);
      chk("sst_be0", 32'(ram_be_o), 32'hE);
      tick();
      idle();
      @(negedge clk);
      chk("sst_be1", 32'(ram_be_o), 32'h1);
      tick();
      drive(1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
      @(negedge clk); tick();
      drive(1'b1, 1'b0, 2'd2, 32'h404, 32'h0);
      @(negedge clk);
      chk("sst_lo", rdata_o, 32'hFEF00D00);
      tick();
      drive(1'b1, 1'b0, 2'd1, 32'h403, 32'h0);
      @(negedge clk);
      chk("sst_hi", rdata_o, 32'h000000CA);
      tick();
      idle();
      @(negedge clk); tick();
      @(negedge clk);
      chk("sph_rdata", rdata_o, 32'h0000CAFE);
      tick();

      drive(1'b1, 1'b1, 2'd2, 32'h7FFC, 32'hAABBCCDD);
      @(negedge clk); tick();
      drive(1'b1, 1'b1, 2'd2, 32'h8000, 32'h11223344);
      @(negedge clk); tick();
      drive(1'b1, 1'b0, 2'd2, 32'h7FFE, 32'h0);
      @(negedge clk);
`ifdef SP_RAM_LSU_ACCESS_ERR_EN
      chk("oob_en", 32'(ram_en_o), 0);
      tick();
      idle();
      @(negedge clk);
      chk("oob_rvalid", 32'(rvalid_o), 1);
      chk("oob_err", 32'(err_o), 1);
      chk("oob_rdata", rdata_o, 32'h0);
      tick();
`else
      chk("wrap_addr0", 32'(ram_addr_o), 32'h7FFC);
      tick();
      idle();
      @(negedge clk);
      chk("wrap_addr1", 32'(ram_addr_o), 32'h8000);
      tick();
      @(negedge clk);
      chk("wrap_rdata", rdata_o, 32'h3344AABB);
      chk("wrap_err", 32'(err_o), 0);
      tick();
`endif

      drive(1'b1, 1'b0, 2'd2, 32'h1FE, 32'h0);
      @(negedge clk); tick();
      idle();
      rst_i = 1'b1;
      @(negedge clk);
      chk("abort_en", 32'(ram_en_o), 0);
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      chk("abort_rvalid", 32'(rvalid_o), 0);
      tick();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
